// File: rtl/ex_iter_unit.sv
// ex_iter_unit: iterative multi-cycle execute unit (PASS, shift-add MUL).
// Optional restoring divider on op 10 when EX_ITER_DIV_EN is defined.
module ex_iter_unit #(
  parameter int WIDTH     = 16,
  parameter int EARLY_OUT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             result_valid,
  output logic             div0,
  output logic             ex_stall
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic EO = (EARLY_OUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic               r_div0;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_b_zero;
  logic               w_direct;
  logic [WIDTH-1:0]   w_dir_res;
  logic [WIDTH-1:0]   w_dir_hi;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_mplier_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_mul_fin;
  logic               w_fin;

  assign w_is_mul = (op_sel == 2'b01);
  assign w_b_zero = (b == '0);

`ifdef EX_ITER_DIV_EN
  logic               r_is_div;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;

  assign w_is_div  = (op_sel == 2'b10);
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_borrow  = w_diff[WIDTH];
  assign w_rem_nxt = w_borrow ? w_rem_sh[WIDTH-1:0]
                              : w_diff[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_fin     = r_is_div ? (w_cnt_nxt == '0) : w_mul_fin;
`else
  assign w_is_div  = 1'b0;
  assign w_fin     = w_mul_fin;
`endif

  assign in_ready = (r_state == IDLE) |
                    ((r_state == DONE) & ~mem_stall);
  assign ex_stall = (r_state == RUN) | (valid_in & ~in_ready);
  assign w_accept = valid_in & in_ready & ~flush;

  assign result       = r_res;
  assign result_hi    = r_res_hi;
  assign result_valid = (r_state == DONE);
`ifdef EX_ITER_DIV_EN
  assign div0 = r_div0;
`else
  assign div0 = 1'b0;
`endif

  // Ops that complete on the accept edge skip RUN entirely.
  assign w_direct = (~w_is_mul & ~w_is_div) |
                    (w_is_mul & EO & w_b_zero) |
                    (w_is_div & w_b_zero);

  assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_nxt = r_mplier >> 1;
  assign w_cnt_nxt    = r_cnt - CW'(1);
  assign w_mul_fin    = (w_cnt_nxt == '0) |
                        (EO & (w_mplier_nxt == '0));

  // Result values for ops finishing on the accept edge.
  always_comb begin
    w_dir_res = a;
    w_dir_hi  = '0;
    unique case (1'b1)
      w_is_mul: begin
        w_dir_res = '0;
        w_dir_hi  = '0;
      end
      w_is_div: begin
        w_dir_res = '1;
        w_dir_hi  = a;
      end
      default: begin
        w_dir_res = a;
        w_dir_hi  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_state_nxt = w_direct ? DONE : RUN;
      end
      RUN: begin
        if (flush)      w_state_nxt = IDLE;
        else if (w_fin) w_state_nxt = DONE;
      end
      DONE: begin
        if (flush)
          w_state_nxt = IDLE;
        else if (!mem_stall)
          w_state_nxt = w_accept ? (w_direct ? DONE : RUN)
                                 : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result latching.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_div0   <= 1'b0;
`ifdef EX_ITER_DIV_EN
      r_is_div <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
`endif
    end else if (flush) begin
      r_div0 <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= CNT_INIT;
      r_div0   <= w_is_div & w_b_zero;
`ifdef EX_ITER_DIV_EN
      r_is_div <= w_is_div;
      r_rem    <= '0;
      r_quo    <= a;
      r_dvs    <= b;
`endif
      if (w_direct) begin
        r_res    <= w_dir_res;
        r_res_hi <= w_dir_hi;
      end
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
`ifdef EX_ITER_DIV_EN
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      if (w_fin && r_is_div) begin
        r_res    <= w_quo_nxt;
        r_res_hi <= w_rem_nxt;
      end else if (w_fin) begin
        r_res    <= w_acc_nxt[WIDTH-1:0];
        r_res_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
      end
`else
      if (w_fin) begin
        r_res    <= w_acc_nxt[WIDTH-1:0];
        r_res_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
      end
`endif
    end
  end

endmodule

// File: tb/tb_ex_iter_unit.sv
// tb_ex_iter_unit: vector table plus hand sequences for ex_iter_unit.
// Two instances cover EARLY_OUT=0 (sel 0) and EARLY_OUT=1 (sel 1).
module tb_ex_iter_unit;

  localparam int W = 16;

  typedef struct {
    logic         sel;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         d0;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         d0;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         valid;
  logic         sel;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         mem_stall;

  logic         rdy0, rv0, d00, st0;
  logic         rdy1, rv1, d01, st1;
  logic [W-1:0] res0, hi0, res1, hi1;

  logic         rdy, rv, d0, st;
  logic [W-1:0] res, hi;

  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  vec_t tbl[$];

  ex_iter_unit #(.WIDTH(W), .EARLY_OUT(0)) u_eo0 (
    .clk(clk), .reset(reset),
    .valid_in(valid & ~sel), .op_sel(op),
    .a(a), .b(b), .flush(flush), .mem_stall(mem_stall),
    .in_ready(rdy0), .result(res0), .result_hi(hi0),
    .result_valid(rv0), .div0(d00), .ex_stall(st0)
  );

  ex_iter_unit #(.WIDTH(W), .EARLY_OUT(1)) u_eo1 (
    .clk(clk), .reset(reset),
    .valid_in(valid & sel), .op_sel(op),
    .a(a), .b(b), .flush(flush), .mem_stall(mem_stall),
    .in_ready(rdy1), .result(res1), .result_hi(hi1),
    .result_valid(rv1), .div0(d01), .ex_stall(st1)
  );

  assign rdy = sel ? rdy1 : rdy0;
  assign rv  = sel ? rv1  : rv0;
  assign d0  = sel ? d01  : d00;
  assign st  = sel ? st1  : st0;
  assign res = sel ? res1 : res0;
  assign hi  = sel ? hi1  : hi0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic s, logic [1:0] o,
                              logic [W-1:0] va, logic [W-1:0] vb,
                              logic [W-1:0] r, logic [W-1:0] h,
                              logic z, int l);
    vec_t v;
    v.sel = s; v.op = o; v.a = va; v.b = vb;
    v.res = r; v.hi = h; v.d0 = z; v.lat = l;
    return v;
  endfunction

  function automatic void push_exp(logic [W-1:0] r,
                                   logic [W-1:0] h, logic z);
    exp_t e;
    e.res = r; e.hi = h; e.d0 = z;
    exp_q.push_back(e);
  endfunction

  task automatic check_pop(string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.sb: got empty queue want entry", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".valid"}, 32'(rv), 32'(1));
      chk({nm, ".res"}, 32'(res), 32'(e.res));
      chk({nm, ".hi"}, 32'(hi), 32'(e.hi));
      chk({nm, ".div0"}, 32'(d0), 32'(e.d0));
    end
  endtask

  // Called at the negedge just after the accept edge.
  task automatic wait_valid(int lat, string nm);
    int n;
    logic stall_ok;
    n = 1;
    stall_ok = 1'b1;
    while (!rv && n < 300) begin
      if (!st) stall_ok = 1'b0;
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, ".lat"}, 32'(n), 32'(lat));
    if (lat > 1)
      chk({nm, ".stall"}, 32'(stall_ok), 32'(1));
  endtask

  task automatic run_op(vec_t v, string nm);
    sel = v.sel; op = v.op; a = v.a; b = v.b;
    valid = 1'b1;
    mem_stall = 1'b0;
    #1;
    chk({nm, ".rdy"}, 32'(rdy), 32'(1));
    push_exp(v.res, v.hi, v.d0);
    @(negedge clk);
    valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 2'($urandom);
    #1;
    wait_valid(v.lat, nm);
    check_pop(nm);
    @(negedge clk);
    #1;
    chk({nm, ".drain"}, 32'(rv), 32'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    valid = 1'b0;
    sel = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    flush = 1'b0;
    mem_stall = 1'b0;

    tbl.push_back(mk(0, 2'b01, 16'h0003, 16'h0005,
                     16'h000F, 16'h0000, 0, 17));
    tbl.push_back(mk(0, 2'b01, 16'hFFFF, 16'hFFFF,
                     16'h0001, 16'hFFFE, 0, 17));
    tbl.push_back(mk(0, 2'b01, 16'h1234, 16'h0000,
                     16'h0000, 16'h0000, 0, 17));
    tbl.push_back(mk(0, 2'b00, 16'h1234, 16'h9999,
                     16'h1234, 16'h0000, 0, 1));
    tbl.push_back(mk(0, 2'b11, 16'hBEEF, 16'h0001,
                     16'hBEEF, 16'h0000, 0, 1));
`ifdef EX_ITER_DIV_EN
    tbl.push_back(mk(0, 2'b10, 16'd100, 16'd7,
                     16'd14, 16'd2, 0, 17));
    tbl.push_back(mk(0, 2'b10, 16'h00AB, 16'h0000,
                     16'hFFFF, 16'h00AB, 1, 1));
    tbl.push_back(mk(0, 2'b10, 16'hFFFF, 16'h0010,
                     16'h0FFF, 16'h000F, 0, 17));
    tbl.push_back(mk(0, 2'b01, 16'h0002, 16'h0003,
                     16'h0006, 16'h0000, 0, 17));
`else
    tbl.push_back(mk(0, 2'b10, 16'd100, 16'd7,
                     16'd100, 16'd0, 0, 1));
    tbl.push_back(mk(0, 2'b10, 16'h00AB, 16'h0000,
                     16'h00AB, 16'h0000, 0, 1));
`endif
    tbl.push_back(mk(1, 2'b01, 16'hFFFF, 16'h0002,
                     16'hFFFE, 16'h0001, 0, 3));
    tbl.push_back(mk(1, 2'b01, 16'hFFFF, 16'h0001,
                     16'hFFFF, 16'h0000, 0, 2));
    tbl.push_back(mk(1, 2'b01, 16'h1234, 16'h0000,
                     16'h0000, 16'h0000, 0, 1));
    tbl.push_back(mk(1, 2'b01, 16'h00FF, 16'h0101,
                     16'hFFFF, 16'h0000, 0, 10));
    tbl.push_back(mk(1, 2'b01, 16'h8000, 16'h8000,
                     16'h0000, 16'h4000, 0, 17));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.res", 32'(res0), 32'(0));
    chk("rst.hi", 32'(hi0), 32'(0));
    chk("rst.valid", 32'(rv0), 32'(0));
    chk("rst.div0", 32'(d00), 32'(0));
    chk("rst.rdy", 32'(rdy0), 32'(1));
    chk("rst.stall", 32'(st0), 32'(0));
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++)
      run_op(tbl[i], $sformatf("vec%0d", i));

    // PASS held under mem_stall while a MUL waits upstream.
    sel = 1'b0; op = 2'b00; a = 16'h1234; b = 16'h0000;
    valid = 1'b1; mem_stall = 1'b0;
    push_exp(16'h1234, 16'h0000, 1'b0);
    @(negedge clk);
    op = 2'b01; a = 16'h0002; b = 16'h0003;
    mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("hold%0d.res", k), 32'(res), 32'h1234);
      chk($sformatf("hold%0d.valid", k), 32'(rv), 32'(1));
      chk($sformatf("hold%0d.rdy", k), 32'(rdy), 32'(0));
      chk($sformatf("hold%0d.stall", k), 32'(st), 32'(1));
    end
    mem_stall = 1'b0;
    #1;
    chk("hold.rdy_release", 32'(rdy), 32'(1));
    check_pop("hold");
    push_exp(16'h0006, 16'h0000, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk("hold.mul_run", 32'(rv), 32'(0));
    chk("hold.mul_stall", 32'(st), 32'(1));
    wait_valid(17, "hold.mul");

    // Back-to-back: PASS accepted on the consuming edge.
    op = 2'b00; a = 16'h0042; b = 16'h0000;
    valid = 1'b1;
    check_pop("b2b.mul");
    push_exp(16'h0042, 16'h0000, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    a = 16'hDEAD;
    #1;
    check_pop("b2b.pass");
    @(negedge clk);
    #1;
    chk("b2b.drain", 32'(rv), 32'(0));

    // Flush on the 5th RUN cycle with a new op presented.
    sel = 1'b0; op = 2'b01; a = 16'h00FF; b = 16'h0101;
    valid = 1'b1;
    #1;
    chk("fl.rdy", 32'(rdy), 32'(1));
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    valid = 1'b1;
    op = 2'b00;
    a = 16'h5555;
    #1;
    chk("fl.stall", 32'(st), 32'(1));
    @(negedge clk);
    flush = 1'b0;
    valid = 1'b0;
    #1;
    chk("fl.valid", 32'(rv), 32'(0));
    chk("fl.div0", 32'(d0), 32'(0));
    chk("fl.rdy_idle", 32'(rdy), 32'(1));
    chk("fl.stall_idle", 32'(st), 32'(0));
    @(negedge clk);
    #1;
    chk("fl.no_accept", 32'(rv), 32'(0));
    run_op(mk(0, 2'b00, 16'h0077, 16'h0000,
              16'h0077, 16'h0000, 0, 1), "fl.next");

    // Asynchronous reset in the middle of RUN.
    sel = 1'b0; op = 2'b01; a = 16'h00FF; b = 16'h0101;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar.res", 32'(res), 32'(0));
    chk("ar.hi", 32'(hi), 32'(0));
    chk("ar.valid", 32'(rv), 32'(0));
    chk("ar.div0", 32'(d0), 32'(0));
    chk("ar.stall", 32'(st), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    run_op(mk(0, 2'b01, 16'h0003, 16'h0005,
              16'h000F, 16'h0000, 0, 17), "ar.next");
    run_op(mk(1, 2'b01, 16'h00FF, 16'h0101,
              16'hFFFF, 16'h0000, 0, 10), "ar.next1");

    chk("sb.empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_iter_unit.md
Name: ex_iter_unit

Overview:
Parametrised multi-cycle execute unit for the execute stage; next generation after the single-cycle ALU path.
- Executes iterative multiply (and optionally divide) one bit per cycle, plus a single-cycle pass op.
- Holds results while the memory stage stalls.
- Raises a stall towards decode while busy, so multi-cycle ops sit in the pipeline without upstream data being dropped.

Parameters:
WIDTH, 16, operand/result width in bits (>=4).
EARLY_OUT, 1, when 1 MUL terminates as soon as the remaining multiplier bits are zero.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
valid_in  input  1  operation presented this cycle
op_sel  input  2  00 PASS, 01 MUL, 10 DIV (feature-dependent), 11 reserved (treated as PASS)
a  input  WIDTH  operand A (multiplicand / dividend)
b  input  WIDTH  operand B (multiplier / divisor)
flush  input  1  synchronous kill of in-flight op (branch/mispredict)
mem_stall  input  1  downstream not consuming this cycle
in_ready  output  1  op accepted this edge if valid_in=1
result  output  WIDTH  PASS: a; MUL: product[WIDTH-1:0]; DIV: quotient
result_hi  output  WIDTH  PASS: 0; MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
result_valid  output  1  result/result_hi/div0 valid
div0  output  1  divide by zero on held DIV result
ex_stall  output  1  upstream must hold its instruction

Behaviour:
- FSM states: IDLE, RUN, DONE. Iteration counter width is $clog2(WIDTH+1). Product register is 2*WIDTH bits.
- Reset (async, any state, including mid-RUN):
  - State goes to IDLE; all registers are cleared.
  - result=0, result_hi=0, result_valid=0, div0=0.
- in_ready = (state==IDLE) | (state==DONE & ~mem_stall). Combinational.
- ex_stall = (state==RUN) | (valid_in & ~in_ready). Combinational.
- Accept occurs on an edge where valid_in & in_ready & ~flush. Operands and op_sel are captured on that edge; later changes to the inputs are ignored.
- PASS/reserved op: goes to DONE on the accept edge. result=a, result_hi=0, so latency is 1.
- MUL (unsigned shift-add):
  - On accept, go to RUN with acc=0, mcand=a zero-extended, mplier=b, cnt=WIDTH.
  - Each RUN edge: if mplier[0], acc+=mcand; then mcand<<=1, mplier>>=1, cnt-=1.
  - Exit to DONE when cnt reaches 0, or, if EARLY_OUT=1, when the post-shift mplier==0.
  - Result is the full 2*WIDTH-bit product, never truncated mid-way.
  - Latency: WIDTH RUN edges when EARLY_OUT=0; 1 + index of the highest set bit of b when EARLY_OUT=1. b=0 with EARLY_OUT=1 goes straight to DONE on the accept edge with product 0.
- DONE: result_valid=1 and outputs are held stable while mem_stall=1. An edge with mem_stall=0 consumes the result:
  - next state is IDLE, or RUN/DONE if a new op is accepted on the same edge (back-to-back, no bubble);
  - result_valid drops only if no new single-cycle op lands.
- flush (synchronous, highest priority after reset):
  - next state is IDLE; result_valid=0 and div0=0 next cycle;
  - no accept occurs on a flush edge, even if valid_in=1;
  - any partial RUN state is discarded.
- mem_stall has no effect in IDLE or RUN; iteration continues during a memory stall.

Optional Feature:
EX_ITER_DIV_EN
- Defined: op 10 is unsigned restoring divide.
  - On accept: rem=0, quo=a, cnt=WIDTH.
  - Each RUN edge shifts {rem,quo} left 1, trial-subtracts b, and sets the quotient bit if there is no borrow. Always WIDTH RUN edges; no early-out.
  - b==0 goes to DONE on the accept edge with result={WIDTH{1}}, result_hi=a, div0=1.
- Undefined: op 10 behaves as PASS, div0 is tied to 0, and no divider logic is synthesised.

Test Plan:
- WIDTH=16, EARLY_OUT=0, MUL a=3 b=5 -> ex_stall high for 16 RUN cycles; result_valid after 16th RUN edge; result=0x000F, result_hi=0x0000.
- EARLY_OUT=1, MUL a=0xFFFF b=0x0002 -> DONE after 2 RUN edges; result=0xFFFE, result_hi=0x0001. b=0x0001 -> DONE after 1 edge, result=0xFFFF.
- PASS a=0x1234 in DONE with mem_stall=1 for 3 cycles, new valid MUL presented -> outputs held at 0x1234, in_ready=0, ex_stall=1; MUL accepted on first mem_stall=0 edge.
- MUL a=0x00FF b=0x0101 started, flush on 5th RUN cycle with valid_in=1 -> IDLE next cycle, result_valid=0, nothing accepted; next op proceeds normally. Repeat with async reset mid-RUN -> all outputs 0 immediately.
- With EX_ITER_DIV_EN: DIV a=100 b=7 -> after 16 RUN edges result=14, result_hi=2, div0=0; DIV a=0x00AB b=0 -> DONE after accept, result=0xFFFF, result_hi=0x00AB, div0=1. Without macro: op 10 a=100 -> result=100 after 1 edge.
- Back-to-back: MUL 2*3 DONE with mem_stall=0 and PASS a=0x0042 valid -> result 0x0006 consumed and 0x0042 valid the next cycle with no bubble.
